// File: rtl/cbus_ram_responder_if.sv
// Cache-side bus types and the request/response interface between a cbus
// initiator (master) and a memory responder (slave).
package cbus_pkg;
  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  strobe;
    logic [31:0] data;
    logic [3:0]  len;
    logic [1:0]  burst;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
    logic        okay;
  } cbus_resp_t;
endpackage

interface cbus_ram_responder_if;
  import cbus_pkg::*;

  cbus_req_t  creq;
  cbus_resp_t cresp;

  modport master (output creq, input cresp);
  modport slave  (input creq, output cresp);
endinterface

// File: rtl/cbus_ram_responder.sv
// Word-addressed RAM responder for the cache-side bus: programmable first-beat
// latency, single/INCR/FIXED bursts, one word per beat with byte strobes.
module cbus_ram_responder #(
  parameter int MEM_WORDS = 1024,
  parameter int LATENCY   = 2
) (
  input  logic                 clk,
  input  logic                 resetn,
  cbus_ram_responder_if.slave  bus,
  output logic [1:0]           dbg_state
);
  import cbus_pkg::*;

  localparam int AW = $clog2(MEM_WORDS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_BEAT = 2'd2
  } state_t;

  // Handshake: a request is accepted on any IDLE-cycle edge where creq.valid
  // is high; the responder then owns the transaction and presents one beat per
  // cycle with ready=1, ignoring valid until it returns to IDLE after last.

  logic [31:0] mem [MEM_WORDS];

  state_t        state, state_nx;
  logic [3:0]    beat, beat_nx;
  logic [3:0]    lat, lat_nx;
  logic [3:0]    len_q;
  logic [AW-1:0] base_q;
  logic [AW-1:0] idx;
  logic          wr_q;
  logic          fixed_q;
  logic          accept;
  logic          unused;

  assign unused = &{1'b0, bus.creq.size, bus.creq.addr[1:0], bus.creq.addr[31:AW+2]};

  always_comb begin
    state_nx = state;
    beat_nx  = beat;
    lat_nx   = lat;
    accept   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.creq.valid) begin
          accept   = 1'b1;
          beat_nx  = 4'd0;
          lat_nx   = 4'(LATENCY);
          state_nx = (LATENCY == 0) ? ST_BEAT : ST_WAIT;
        end
      end
      ST_WAIT: begin
        lat_nx = (lat == 4'd0) ? 4'd0 : lat - 4'd1;
        if (lat <= 4'd1) state_nx = ST_BEAT;
      end
      ST_BEAT: begin
        beat_nx = beat + 4'd1;
        if (beat == len_q) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= ST_IDLE;
      beat    <= 4'd0;
      lat     <= 4'd0;
      len_q   <= 4'd0;
      base_q  <= '0;
      wr_q    <= 1'b0;
      fixed_q <= 1'b0;
    end else begin
      state <= state_nx;
      beat  <= beat_nx;
      lat   <= lat_nx;
      if (accept) begin
        len_q   <= bus.creq.len;
        base_q  <= bus.creq.addr[AW+1:2];
        wr_q    <= bus.creq.is_write;
        fixed_q <= (bus.creq.burst == BURST_FIXED);
      end
    end
  end

  // Index arithmetic is AW bits wide, so INCR bursts wrap at the top word.
  assign idx = fixed_q ? base_q : base_q + AW'(beat);

  always_comb begin
    bus.cresp = '0;
    if (state == ST_BEAT) begin
      bus.cresp.ready = 1'b1;
      bus.cresp.okay  = 1'b1;
      bus.cresp.last  = (beat == len_q);
      bus.cresp.data  = wr_q ? 32'd0 : mem[idx];
    end
  end

  // Reset gates the write so a burst cut short leaves later beats untouched.
  always_ff @(posedge clk) begin
    if (resetn && state == ST_BEAT && wr_q) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.creq.strobe[i]) mem[idx][8*i +: 8] <= bus.creq.data[8*i +: 8];
      end
    end
  end

  assign dbg_state = state;
endmodule

// File: tb/tb_cbus_ram_responder.sv
// Directed bench for cbus_ram_responder: one instance at LATENCY=2, one at
// LATENCY=0, sharing a request driver steered by sel.
module tb_cbus_ram_responder;
  import cbus_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  cbus_ram_responder_if bus_a ();
  cbus_ram_responder_if bus_b ();
  logic [1:0] st_a, st_b;

  cbus_ram_responder #(.MEM_WORDS(1024), .LATENCY(2)) dut_a (
    .clk(clk), .resetn(resetn), .bus(bus_a), .dbg_state(st_a));
  cbus_ram_responder #(.MEM_WORDS(1024), .LATENCY(0)) dut_b (
    .clk(clk), .resetn(resetn), .bus(bus_b), .dbg_state(st_b));

  cbus_req_t  req;
  cbus_resp_t rsp;
  logic       sel;

  always_comb begin
    bus_a.creq       = req;
    bus_a.creq.valid = req.valid & ~sel;
    bus_b.creq       = req;
    bus_b.creq.valid = req.valid & sel;
    rsp              = sel ? bus_b.cresp : bus_a.cresp;
  end

  // scoreboard
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_q [$];
  logic [31:0] wd_q [$];
  logic [3:0]  ws_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, " ctl"}, {29'd0, rsp.ready, rsp.last, rsp.okay}, 32'd0);
    check({tag, " data"}, rsp.data, 32'd0);
  endtask

  // driver tasks
  task automatic present(input logic wr, input logic [31:0] a, input int ln, input logic [1:0] bu);
    req.valid    = 1'b1;
    req.is_write = wr;
    req.size     = 2'd2;
    req.addr     = a;
    req.len      = 4'(ln);
    req.burst    = bu;
    req.data     = 32'd0;
    req.strobe   = 4'd0;
  endtask

  // Waits for the acceptance edge, then follows the beats; returns at the
  // falling edge inside the last beat cycle.
  task automatic serve(input logic wr, input int ln, input int lat, input string tag);
    int n = 0;
    int beat = 0;
    bit done = 1'b0;
    @(posedge clk);
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
      if (n == 1) req.valid = 1'b0;
      if (rsp.ready) begin
        if (beat == 0) check({tag, " latency"}, 32'(n), 32'(lat + 1));
        check({tag, " okay"}, 32'(rsp.okay), 32'd1);
        check({tag, " last"}, 32'(rsp.last), 32'(beat == ln));
        if (wr) begin
          check({tag, " wdata"}, rsp.data, 32'd0);
          req.data   = wd_q.pop_front();
          req.strobe = ws_q.pop_front();
        end else begin
          check({tag, " rdata"}, rsp.data, exp_q.pop_front());
        end
        if (beat == ln) done = 1'b1;
        beat++;
      end else if (beat > 0) begin
        check({tag, " gap"}, 32'(rsp.ready), 32'd1);
        done = 1'b1;
      end
    end
    check({tag, " beats"}, 32'(beat), 32'(ln + 1));
  endtask

  task automatic wr_txn(input logic [31:0] a, input int ln, input logic [1:0] bu, input string tag);
    @(negedge clk);
    present(1'b1, a, ln, bu);
    serve(1'b1, ln, sel ? 0 : 2, tag);
    @(negedge clk);
    check_idle({tag, " after"});
  endtask

  task automatic rd_txn(input logic [31:0] a, input int ln, input logic [1:0] bu, input string tag);
    @(negedge clk);
    present(1'b0, a, ln, bu);
    serve(1'b0, ln, sel ? 0 : 2, tag);
    @(negedge clk);
    check_idle({tag, " after"});
  endtask

  task automatic push_w(input logic [31:0] d, input logic [3:0] s);
    wd_q.push_back(d);
    ws_q.push_back(s);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int beat;
    req    = '0;
    sel    = 1'b0;
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    check_idle("reset");
    check("reset state a", 32'(st_a), 32'd0);
    check("reset state b", 32'(st_b), 32'd0);

    // preload through the bus
    push_w(32'hDEADBEEF, 4'hF);
    wr_txn(32'h14, 0, BURST_INCR, "pre 5");
    push_w(32'd1, 4'hF); push_w(32'd2, 4'hF); push_w(32'd3, 4'hF); push_w(32'd4, 4'hF);
    wr_txn(32'h40, 3, BURST_INCR, "pre 16");

    // single read and INCR burst read
    exp_q.push_back(32'hDEADBEEF);
    rd_txn(32'h14, 0, BURST_INCR, "single rd");
    for (int i = 1; i <= 4; i++) exp_q.push_back(32'(i));
    rd_txn(32'h40, 3, BURST_INCR, "incr rd");

    // strobed write burst on zeroed words
    push_w(32'd0, 4'hF); push_w(32'd0, 4'hF);
    wr_txn(32'h100, 1, BURST_INCR, "zero 64");
    push_w(32'hAAAAAAAA, 4'b0011); push_w(32'hBBBBBBBB, 4'b1100);
    wr_txn(32'h100, 1, BURST_INCR, "strb wr");
    exp_q.push_back(32'h0000AAAA); exp_q.push_back(32'hBBBB0000);
    rd_txn(32'h100, 1, BURST_INCR, "strb rd");

    // wrap from the top word to word 0; upper address bits ignored
    push_w(32'hC0DE0001, 4'hF); push_w(32'hC0DE0002, 4'hF);
    wr_txn(32'hFFC, 1, BURST_INCR, "wrap wr");
    exp_q.push_back(32'hC0DE0001); exp_q.push_back(32'hC0DE0002);
    rd_txn(32'hFFC, 1, BURST_INCR, "wrap rd");
    exp_q.push_back(32'hC0DE0002);
    rd_txn(32'h1000, 0, BURST_INCR, "alias rd");

    // FIXED burst hits one word only
    push_w(32'h33, 4'hF);
    wr_txn(32'hC, 0, BURST_INCR, "pre 3");
    push_w(32'd7, 4'hF); push_w(32'd8, 4'hF); push_w(32'd9, 4'hF);
    wr_txn(32'h8, 2, BURST_FIXED, "fixed wr");
    exp_q.push_back(32'd9); exp_q.push_back(32'h33);
    rd_txn(32'h8, 1, BURST_INCR, "fixed rd");

    // reset during beat 2 of a 4-beat write
    for (int i = 0; i < 4; i++) push_w(32'd0, 4'hF);
    wr_txn(32'h140, 3, BURST_INCR, "zero 80");
    @(negedge clk);
    present(1'b1, 32'h140, 3, BURST_INCR);
    n = 0;
    beat = 0;
    @(posedge clk);
    while (beat < 3 && n < 40) begin
      @(negedge clk);
      n++;
      if (n == 1) req.valid = 1'b0;
      if (rsp.ready) begin
        req.data   = 32'h11 * 32'(beat + 1);
        req.strobe = 4'hF;
        if (beat == 2) resetn = 1'b0;
        beat++;
      end
    end
    check("rst mid beats", 32'(beat), 32'd3);
    @(negedge clk);
    check_idle("rst mid");
    check("rst mid state", 32'(st_a), 32'd0);
    resetn = 1'b1;
    exp_q.push_back(32'h11); exp_q.push_back(32'h22);
    exp_q.push_back(32'd0);  exp_q.push_back(32'd0);
    rd_txn(32'h140, 3, BURST_INCR, "rst mid rd");

    // zero latency and back-to-back reads
    sel = 1'b1;
    push_w(32'h5555, 4'hF); push_w(32'h6666, 4'hF);
    wr_txn(32'h20, 1, BURST_INCR, "b pre");
    exp_q.push_back(32'h5555);
    @(negedge clk);
    present(1'b0, 32'h20, 0, BURST_INCR);
    serve(1'b0, 0, 0, "b2b first");
    present(1'b0, 32'h24, 0, BURST_INCR);
    exp_q.push_back(32'h6666);
    @(negedge clk);
    check_idle("b2b gap");
    serve(1'b0, 0, 0, "b2b second");
    @(negedge clk);
    check_idle("b2b after");

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
